// File: rtl/wb_timer_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one slave (timer adapter).
// Optional stalled-strobe abort is compiled in with WB_ARB_TIMEOUT_EN.
module wb_timer_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   last;
  logic   last_nx;
  logic   req0;
  logic   req1;
  logic   own0;
  logic   own1;
  logic   tmo;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign own0 = (state == GNT0);
  assign own1 = (state == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt;
  logic                 stall;

  assign stall = (own0 & req0) | (own1 & req1);
  assign tmo   = stall & ~s_ack_i
               & (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Cleared while idle, so every new grant starts from zero
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE || tmo || s_ack_i) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign m0_err_o = own0 & tmo;
  assign m1_err_o = own1 & tmo;
`else
  assign tmo      = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (req0 & req1) begin
          state_nx = last ? GNT0 : GNT1;
        end else if (req0) begin
          state_nx = GNT0;
        end else if (req1) begin
          state_nx = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || tmo) begin
          state_nx = IDLE;
          last_nx  = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || tmo) begin
          state_nx = IDLE;
          last_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Ack is gated by the owner's CYC so a late slave ack is dropped
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_data_o = '0;
    case (state)
      GNT0: begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_sel_o   = m0_sel_i;
        s_we_o    = m0_we_i;
        s_cyc_o   = m0_cyc_i & ~tmo;
        s_stb_o   = req0 & ~tmo;
        m0_ack_o  = m0_cyc_i & s_ack_i;
        m0_data_o = s_data_i;
      end
      GNT1: begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_sel_o   = m1_sel_i;
        s_we_o    = m1_we_i;
        s_cyc_o   = m1_cyc_i & ~tmo;
        s_stb_o   = req1 & ~tmo;
        m1_ack_o  = m1_cyc_i & s_ack_i;
        m1_data_o = s_data_i;
      end
      default: ;
    endcase
  end

endmodule
